// File: rtl/cordic_rot_pipe.sv
// Pipelined rotation-mode CORDIC: folded phase plus quadrant flag in, Q1.14 cos/sin of the
// original phase out, one sample per clock, fixed latency ITER+2.
module cordic_rot_pipe #(
  parameter int ITER   = 16,
  parameter int OUT_W  = 16,
  parameter int IW     = 20,
  parameter int X_INIT = 9949
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    in_valid,
  input  logic signed [21:0]      phase_pre,
  input  logic [1:0]              quadrant_flag,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] cos_out,
  output logic signed [OUT_W-1:0] sin_out
);
  localparam int ZW = 22;
  // IW-OUT_W guard bits sit below the Q1.14 LSB to absorb shift truncation
  localparam int GB = IW - OUT_W;
  localparam int RW = OUT_W + 1;
  localparam logic signed [IW-1:0] X0      = IW'(X_INIT * (2 ** GB));
  localparam logic signed [IW:0]   HALF    = (IW+1)'(2 ** (GB - 1));
  localparam logic signed [RW-1:0] POS_ONE = RW'(2 ** (OUT_W - 2));
  localparam logic signed [RW-1:0] NEG_ONE = -POS_ONE;

  function automatic logic signed [ZW-1:0] atan_rom(input int i);
    case (i)
      0:       atan_rom = 22'sd450000;
      1:       atan_rom = 22'sd265651;
      2:       atan_rom = 22'sd140362;
      3:       atan_rom = 22'sd71250;
      4:       atan_rom = 22'sd35763;
      5:       atan_rom = 22'sd17899;
      6:       atan_rom = 22'sd8952;
      7:       atan_rom = 22'sd4476;
      8:       atan_rom = 22'sd2238;
      9:       atan_rom = 22'sd1119;
      10:      atan_rom = 22'sd560;
      11:      atan_rom = 22'sd280;
      12:      atan_rom = 22'sd140;
      13:      atan_rom = 22'sd70;
      14:      atan_rom = 22'sd35;
      15:      atan_rom = 22'sd17;
      default: atan_rom = '0;
    endcase
  endfunction

  // Round half-up from the guard-bit format back to Q1.14
  function automatic logic signed [RW-1:0] round_q14(input logic signed [IW-1:0] v);
    logic signed [IW:0] t;
    t = {v[IW-1], v} + HALF;
    return t[IW:GB];
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_q14(input logic signed [RW-1:0] v);
    if (v > POS_ONE) return POS_ONE[OUT_W-1:0];
    if (v < NEG_ONE) return NEG_ONE[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  logic signed [IW-1:0] x_p [0:ITER];
  logic signed [IW-1:0] y_p [0:ITER];
  logic signed [ZW-1:0] z_p [0:ITER-1];
  logic [ITER:0]        vld_p;
  logic [ITER:0]        neg_p;
  logic signed [IW-1:0] x_fin, y_fin;
  logic                 unused_flag_msb;

  // Only bit 0 (Q2/Q3) decides the output sign; Q4 is already a signed folded phase.
  assign unused_flag_msb = quadrant_flag[1];

  always_comb begin
    x_fin = neg_p[ITER] ? -x_p[ITER] : x_p[ITER];
    y_fin = neg_p[ITER] ? -y_p[ITER] : y_p[ITER];
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p     <= '0;
      neg_p     <= '0;
      out_valid <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
      for (int i = 0; i <= ITER; i++) begin
        x_p[i] <= '0;
        y_p[i] <= '0;
      end
      for (int i = 0; i < ITER; i++) z_p[i] <= '0;
    end else begin
      // stage 0: input register
      vld_p  <= {vld_p[ITER-1:0], in_valid};
      neg_p  <= {neg_p[ITER-1:0], quadrant_flag[0]};
      x_p[0] <= X0;
      y_p[0] <= '0;
      z_p[0] <= phase_pre;
      // stages 1..ITER: micro-rotations
      for (int i = 0; i < ITER; i++) begin
        if (!z_p[i][ZW-1]) begin
          x_p[i+1] <= x_p[i] - (y_p[i] >>> i);
          y_p[i+1] <= y_p[i] + (x_p[i] >>> i);
        end else begin
          x_p[i+1] <= x_p[i] + (y_p[i] >>> i);
          y_p[i+1] <= y_p[i] - (x_p[i] >>> i);
        end
      end
      for (int i = 0; i < ITER - 1; i++) begin
        z_p[i+1] <= z_p[i][ZW-1] ? z_p[i] + atan_rom(i) : z_p[i] - atan_rom(i);
      end
      // stage ITER+1: quadrant correction, rounding, saturation
      out_valid <= vld_p[ITER];
      cos_out   <= sat_q14(round_q14(x_fin));
      sin_out   <= sat_q14(round_q14(y_fin));
    end
  end
endmodule
